// File: rtl/ap_hs_driver.sv
// ap_hs_driver: sequences one valid/ready request at a time into an ap_ctrl_hs callee and returns its result.
// Optional watchdog abort is compiled in with `define HS_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module ap_hs_driver #(
  parameter int ARG_W          = 32,
  parameter int RES_W          = 32,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ARG_W-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic [CNT_W-1:0] job_cnt,
  output logic             c_ap_start,
  input  logic             c_ap_ready,
  input  logic             c_ap_done,
  input  logic             c_ap_idle,
  output logic [ARG_W-1:0] c_num,
  input  logic [RES_W-1:0] c_ap_return
);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t           state_reg;
  logic             c_ap_start_reg;
  logic [ARG_W-1:0] c_num_reg;
  logic [RES_W-1:0] rsp_data_reg;
  logic [CNT_W-1:0] job_cnt_reg;
  logic             wd_expired;

  // Callee idle is status only and never steers the sequencer.
  logic unused_idle;
  assign unused_idle = c_ap_idle;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_reg      <= IDLE;
      c_ap_start_reg <= 1'b0;
      c_num_reg      <= '0;
      rsp_data_reg   <= '0;
      job_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            c_num_reg      <= req_data;
            c_ap_start_reg <= 1'b1;
            state_reg      <= START;
          end
        end
        START: begin
          // Done wins over both ready and watchdog expiry.
          if (c_ap_done) begin
            c_ap_start_reg <= 1'b0;
            rsp_data_reg   <= c_ap_return;
            state_reg      <= RESP;
          end else if (wd_expired) begin
            c_ap_start_reg <= 1'b0;
            rsp_data_reg   <= '0;
            state_reg      <= RESP;
          end else if (c_ap_ready) begin
            c_ap_start_reg <= 1'b0;
            state_reg      <= WAIT;
          end
        end
        WAIT: begin
          if (c_ap_done) begin
            rsp_data_reg <= c_ap_return;
            state_reg    <= RESP;
          end else if (wd_expired) begin
            rsp_data_reg <= '0;
            state_reg    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            job_cnt_reg <= job_cnt_reg + CNT_W'(1);
            state_reg   <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef HS_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [WD_W-1:0] wd_reg;
  logic            rsp_err_reg;

  assign wd_expired = (state_reg == START || state_reg == WAIT) &&
                      (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));

  // Held at zero while IDLE so it starts from zero on every entry to START.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wd_reg      <= '0;
      rsp_err_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE) begin
        wd_reg <= '0;
      end else if (state_reg == START || state_reg == WAIT) begin
        wd_reg <= wd_reg + WD_W'(1);
        if (c_ap_done) begin
          rsp_err_reg <= 1'b0;
        end else if (wd_expired) begin
          rsp_err_reg <= 1'b1;
        end
      end
    end
  end

  assign rsp_err = rsp_err_reg;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
  assign wd_expired     = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  assign req_ready  = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign rsp_valid  = (state_reg == RESP);
  assign rsp_data   = rsp_data_reg;
  assign job_cnt    = job_cnt_reg;
  assign c_ap_start = c_ap_start_reg;
  assign c_num      = c_num_reg;

endmodule

// File: tb/tb_ap_hs_driver.sv
// Testbench for ap_hs_driver: factorial callee model, directed and random jobs, queue scoreboard.
// With HS_TIMEOUT_EN defined it also exercises the watchdog abort path.
`timescale 1ns/1ps
module tb_ap_hs_driver;
  localparam int ARG_W = 32;
  localparam int RES_W = 32;
  localparam int CNT_W = 4;
  localparam int TO    = 16;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n = 1'b0;
  logic             req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, busy;
  logic [ARG_W-1:0] req_data, c_num;
  logic [RES_W-1:0] rsp_data, c_ap_return;
  logic [CNT_W-1:0] job_cnt;
  logic             c_ap_start, c_ap_ready, c_ap_done, c_ap_idle;

  always #5 ap_clk = ~ap_clk;

  ap_hs_driver #(.ARG_W(ARG_W), .RES_W(RES_W), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .job_cnt(job_cnt),
    .c_ap_start(c_ap_start), .c_ap_ready(c_ap_ready), .c_ap_done(c_ap_done),
    .c_ap_idle(c_ap_idle), .c_num(c_num), .c_ap_return(c_ap_return)
  );

  typedef struct {
    logic [RES_W-1:0] data;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cfg_rdly = 0;
  int   cfg_dlat = 0;
  bit   cfg_never = 0;
  bit   inject_done = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, got, exp);
  endtask

  function automatic logic [RES_W-1:0] fact(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 2; i <= n; i++) p = p * longint'(i);
    return p[RES_W-1:0];
  endfunction

  // Callee: ready rdly cycles after start is first seen, done dlat cycles after ready.
  initial begin : callee
    bit               active, rdy_seen, never;
    int               st_cnt, dn_cnt, rdly, dlat;
    logic [ARG_W-1:0] arg;
    active = 0; rdy_seen = 0; never = 0; st_cnt = 0; dn_cnt = 0; rdly = 0; dlat = 0; arg = '0;
    c_ap_ready = 0; c_ap_done = 0; c_ap_idle = 1; c_ap_return = '0;
    forever begin
      @(posedge ap_clk); #1;
      c_ap_ready  = 0;
      c_ap_done   = 0;
      c_ap_return = $urandom;
      if (inject_done) begin
        c_ap_done   = 1;
        inject_done = 0;
      end
      if (!active && c_ap_start) begin
        active = 1; rdy_seen = 0; st_cnt = 0; dn_cnt = 0;
        arg = c_num; rdly = cfg_rdly; dlat = cfg_dlat; never = cfg_never;
      end
      if (active && !rdy_seen) begin
        if (st_cnt == rdly) begin
          c_ap_ready = 1;
          rdy_seen   = 1;
        end else st_cnt++;
      end
      if (active && rdy_seen) begin
        if (dn_cnt == dlat) begin
          if (!never) begin
            c_ap_done   = 1;
            c_ap_return = fact(int'(arg));
          end
          active = 0;
        end else dn_cnt++;
      end
      c_ap_idle = !active;
    end
  end

  // Monitor: compares every response handshake against the scoreboard, then the count after it.
  initial begin : monitor
    int   exp_cnt;
    bit   hs_pending;
    exp_t e;
    exp_cnt = 0; hs_pending = 0;
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        exp_cnt    = 0;
        hs_pending = 0;
      end else begin
        if (hs_pending) begin
          chk("job_cnt", 64'(job_cnt), 64'(exp_cnt[CNT_W-1:0]));
          chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
          hs_pending = 0;
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_rsp: got data %0d, required no response", rsp_data);
          end else begin
            e = exp_q.pop_front();
            $display("rsp data=%0d err=%0d (exp %0d/%0d)", rsp_data, rsp_err, e.data, e.err);
            chk("rsp_data", 64'(rsp_data), 64'(e.data));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
          end
          exp_cnt    = (exp_cnt + 1) % (1 << CNT_W);
          hs_pending = 1;
        end
      end
    end
  end

  // One job; entered and left at posedge+1. Cycle 0 is the first cycle after the request handshake.
  task automatic run_job(input logic [ARG_W-1:0] arg, input int rdly, input int dlat, input int bp,
                         input bit never, input bit hold_req, input bit expect_now, input string tag);
    int               n, start_len, first_start, valid_cyc, vcount, exp_vcyc;
    bit               num_ok, rr_ok, stable, done_hs;
    logic [RES_W-1:0] first_data;
    logic             first_err;
    exp_t             e;
    cfg_rdly = rdly; cfg_dlat = dlat; cfg_never = never;
    req_valid = 1; req_data = arg; rsp_ready = 0;
    n = 0;
    do begin
      @(negedge ap_clk);
      n++;
    end while (!req_ready && n < 64);
    if (!req_ready) begin
      n_checks++;
      $display("FAIL %s_accept: req_ready still 0 after %0d cycles, required 1", tag, n);
      req_valid = 0;
      return;
    end
    if (expect_now) chk({tag, "_ready_after_hs"}, 64'(n), 64'd1);
    @(posedge ap_clk); #1;
    req_valid = hold_req;
    e.data = never ? '0 : fact(int'(arg));
    e.err  = never;
    exp_q.push_back(e);
    $display("req %s arg=%0d rdly=%0d dlat=%0d bp=%0d", tag, arg, rdly, dlat, bp);
    exp_vcyc = never ? TO : rdly + dlat + 1;
    num_ok = 1; rr_ok = 1; stable = 1; done_hs = 0;
    start_len = 0; first_start = -1; valid_cyc = -1; vcount = 0;
    first_data = '0; first_err = 0;
    for (int cyc = 0; cyc < 400 && !done_hs; cyc++) begin
      @(negedge ap_clk);
      if (c_ap_start) begin
        start_len++;
        if (first_start < 0) first_start = cyc;
      end
      if (c_num !== arg) num_ok = 0;
      if (req_ready) rr_ok = 0;
      if (rsp_valid) begin
        if (vcount == 0) begin
          valid_cyc  = cyc;
          first_data = rsp_data;
          first_err  = rsp_err;
        end else if (rsp_data !== first_data || rsp_err !== first_err) stable = 0;
        vcount++;
        if (rsp_ready) done_hs = 1;
      end
      @(posedge ap_clk); #1;
      rsp_ready = (vcount > bp) && !done_hs;
    end
    if (!done_hs) begin
      n_checks++;
      $display("FAIL %s_rsp_hs: no response handshake within 400 cycles, required one", tag);
    end
    chk({tag, "_start_cycle"}, 64'(first_start), 64'd0);
    chk({tag, "_start_len"}, 64'(start_len), 64'(rdly + 1));
    chk({tag, "_c_num_stable"}, 64'(num_ok), 64'd1);
    chk({tag, "_req_ready_low"}, 64'(rr_ok), 64'd1);
    chk({tag, "_rsp_stable"}, 64'(stable), 64'd1);
    chk({tag, "_rsp_latency"}, 64'(valid_cyc), 64'(exp_vcyc));
  endtask

  initial begin : stim
    bit saw_valid, saw_done;
    int gap;
    req_valid = 0; req_data = '0; rsp_ready = 0;

    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst_c_ap_start", 64'(c_ap_start), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_c_num", 64'(c_num), 64'd0);
    chk("rst_job_cnt", 64'(job_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge ap_clk); #1;
    ap_rst_n = 1;
    @(negedge ap_clk);
    chk("rel_req_ready", 64'(req_ready), 64'd1);
    @(posedge ap_clk); #1;

    run_job(5, 0, 3, 0, 0, 0, 0, "fact5");
    run_job(10, 4, 2, 1, 0, 0, 0, "slow_ready");
    run_job(0, 0, 0, 0, 0, 0, 0, "skip_wait");
    run_job(3, 0, 2, 5, 0, 1, 0, "bp_first");
    run_job(3, 1, 1, 0, 0, 0, 1, "bp_second");

    // Reset while the driver waits for done; the callee still fires done later.
    cfg_rdly = 0; cfg_dlat = 14; cfg_never = 0;
    req_valid = 1; req_data = 7;
    gap = 0;
    do begin
      @(negedge ap_clk);
      gap++;
    end while (!req_ready && gap < 64);
    @(posedge ap_clk); #1;
    req_valid = 0;
    $display("req rst_mid arg=7 (aborted by reset)");
    repeat (3) begin @(posedge ap_clk); #1; end
    chk("pre_rst_busy", 64'(busy), 64'd1);
    ap_rst_n = 0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_c_ap_start", 64'(c_ap_start), 64'd0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_c_num", 64'(c_num), 64'd0);
    chk("midrst_job_cnt", 64'(job_cnt), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1;
    saw_valid = 0; saw_done = 0;
    repeat (20) begin
      @(negedge ap_clk);
      saw_valid |= rsp_valid;
      saw_done  |= c_ap_done;
    end
    chk("stray_done_seen", 64'(saw_done), 64'd1);
    chk("stray_done_no_rsp", 64'(saw_valid), 64'd0);
    chk("stray_done_job_cnt", 64'(job_cnt), 64'd0);
    chk("stray_done_idle", 64'(busy), 64'd0);
    @(posedge ap_clk); #1;

    // Random jobs; 16 handshakes after reset also wrap the 4-bit counter back to 0.
    for (int j = 0; j < 16; j++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) begin @(posedge ap_clk); #1; end
      run_job($urandom_range(0, 12), $urandom_range(0, 4), $urandom_range(0, 6),
              $urandom_range(0, 3), 0, 0, 0, $sformatf("rnd%0d", j));
    end

`ifdef HS_TIMEOUT_EN
    run_job(4, 0, 0, 1, 1, 0, 0, "timeout");
    inject_done = 1;
    saw_valid = 0;
    repeat (20) begin
      @(negedge ap_clk);
      saw_valid |= rsp_valid;
    end
    chk("late_done_no_rsp", 64'(saw_valid), 64'd0);
    @(posedge ap_clk); #1;
`endif

    repeat (3) @(negedge ap_clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

endmodule
